// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache fetch controller.
package icache_pkg;

  // The state names the owner of the response that is due in the current cycle.
  typedef enum logic [1:0] {
    StIdle,
    StIfResp,
    StDbgResp,
    StIfHold
  } fetch_state_e;

  localparam int unsigned DBG_MAX_WAIT_DEFAULT = 8;

  localparam logic REQ_ID_IF  = 1'b0;
  localparam logic REQ_ID_DBG = 1'b1;

endpackage

// File: rtl/icache_arb.sv
// Fetch/debug arbiter: fetch has priority, and debug wins once it has waited DBG_MAX_WAIT cycles.
module icache_arb
  import icache_pkg::*;
#(
  parameter int unsigned DBG_MAX_WAIT = DBG_MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic dbg_req,
  input  logic flush,
  input  logic block,
  output logic gnt_valid,
  output logic gnt_id
);

  localparam int unsigned CntW = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxWait = CntW'(DBG_MAX_WAIT);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            dbg_win, if_gnt, dbg_gnt;

  // flush only masks the fetch grant; the debug decision is computed without it
  always_comb begin
    dbg_win    = dbg_req && (wait_cnt_q >= MaxWait);
    dbg_gnt    = reset && !block && dbg_req && (dbg_win || !if_req);
    if_gnt     = reset && !block && if_req && !dbg_win && !flush;
    gnt_valid  = if_gnt || dbg_gnt;
    gnt_id     = dbg_gnt ? REQ_ID_DBG : REQ_ID_IF;
    wait_cnt_d = '0;
    if (dbg_req && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Instruction-cache fetch controller arbitrating the fetch stage and a debug read port.
// Optional performance counters are enabled by defining ICACHE_FETCH_CTRL_PERF_EN.
module icache_fetch_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DBG_MAX_WAIT = DBG_MAX_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  if_ready,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  input  logic                  flush,
  output logic                  ic_enable,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic [DATA_WIDTH-1:0] ic_data,
`ifdef ICACHE_FETCH_CTRL_PERF_EN
  output logic [31:0]           perf_if_fetches,
  output logic [31:0]           perf_dbg_reads,
  output logic [31:0]           perf_stall_cycles,
`endif
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] WordMask = ~ADDR_WIDTH'(3);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  if_resp, arb_block, gnt_valid, gnt_id;

  icache_arb #(
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .dbg_req  (dbg_req),
    .flush    (flush),
    .block    (arb_block),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // An unaccepted fetch response blocks new grants so it cannot be overtaken.
  always_comb begin
    if_resp    = (state_q == StIfResp) || (state_q == StIfHold);
    arb_block  = if_resp && !if_ready;
    if_gnt     = gnt_valid && (gnt_id == REQ_ID_IF);
    dbg_gnt    = gnt_valid && (gnt_id == REQ_ID_DBG);
    ic_enable  = gnt_valid;
    ic_addr    = '0;
    if (gnt_valid) begin
      ic_addr = (dbg_gnt ? dbg_addr : if_addr) & WordMask;
    end
    if_rvalid  = if_resp && !flush;
    if_rdata   = '0;
    if (if_rvalid) begin
      if_rdata = (state_q == StIfHold) ? hold_q : ic_data;
    end
    dbg_rvalid = (state_q == StDbgResp);
    dbg_rdata  = dbg_rvalid ? ic_data : '0;
    busy       = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      if (dbg_gnt) begin
        state_q <= StDbgResp;
      end else if (if_gnt) begin
        state_q <= StIfResp;
      end else if (if_resp && !if_ready && !flush) begin
        state_q <= StIfHold;
      end else begin
        state_q <= StIdle;
      end
      if (state_q == StIfResp && !if_ready && !flush) begin
        hold_q <= ic_data;
      end else if (state_q == StIfHold && (if_ready || flush)) begin
        hold_q <= '0;
      end
    end
  end

`ifdef ICACHE_FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_fetches   <= '0;
      perf_dbg_reads    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_gnt) perf_if_fetches <= perf_if_fetches + 32'd1;
      if (dbg_gnt) perf_dbg_reads <= perf_dbg_reads + 32'd1;
      if (state_q == StIfHold && !if_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Self-checking bench for icache_fetch_ctrl: directed scenarios plus a randomized run vs a model.
module tb_icache_fetch_ctrl;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, if_ready = 1'b1, dbg_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, dbg_addr = '0, ic_data = '0;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, ic_enable, busy;
  logic [31:0] if_rdata, dbg_rdata, ic_addr;
`ifdef ICACHE_FETCH_CTRL_PERF_EN
  logic [31:0] perf_if_fetches, perf_dbg_reads, perf_stall_cycles;
  logic [31:0] m_perf_if, m_perf_dbg, m_perf_stall;
  bit          m_if_held;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: outstanding responses as records of the word they must deliver.
  bit          m_if_pend, m_dbg_pend;
  logic [31:0] m_if_word, m_dbg_word;
  int          m_starve;
  logic        exp_if_gnt, exp_dbg_gnt, exp_ic_enable, exp_if_rvalid, exp_dbg_rvalid, exp_busy;
  logic [31:0] exp_ic_addr, exp_if_rdata, exp_dbg_rdata;

  icache_fetch_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_gnt           (if_gnt),
    .if_rvalid        (if_rvalid),
    .if_rdata         (if_rdata),
    .if_ready         (if_ready),
    .dbg_req          (dbg_req),
    .dbg_addr         (dbg_addr),
    .dbg_gnt          (dbg_gnt),
    .dbg_rvalid       (dbg_rvalid),
    .dbg_rdata        (dbg_rdata),
    .flush            (flush),
    .ic_enable        (ic_enable),
    .ic_addr          (ic_addr),
    .ic_data          (ic_data),
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    .perf_if_fetches  (perf_if_fetches),
    .perf_dbg_reads   (perf_dbg_reads),
    .perf_stall_cycles(perf_stall_cycles),
`endif
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]} ^ 32'hC0DE_0000;
  endfunction

  // One-cycle-latency cache; garbage when not enabled so stale data is visible.
  always @(posedge clk) ic_data <= ic_enable ? mem_word(ic_addr) : $urandom();

  task automatic model_reset();
    m_if_pend = 0; m_dbg_pend = 0; m_if_word = '0; m_dbg_word = '0; m_starve = 0;
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    m_if_held = 0; m_perf_if = '0; m_perf_dbg = '0; m_perf_stall = '0;
`endif
  endtask

  task automatic model_eval();
    bit blocked, dbg_wins;
    blocked  = m_if_pend && !if_ready;
    dbg_wins = dbg_req && (m_starve >= MAXW);
    exp_dbg_gnt    = reset && !blocked && dbg_req && (dbg_wins || !if_req);
    exp_if_gnt     = reset && !blocked && if_req && !dbg_wins && !flush;
    exp_ic_enable  = exp_dbg_gnt || exp_if_gnt;
    exp_ic_addr    = exp_dbg_gnt ? (dbg_addr & ~32'h3) : exp_if_gnt ? (if_addr & ~32'h3) : 32'h0;
    exp_if_rvalid  = reset && m_if_pend && !flush;
    exp_if_rdata   = exp_if_rvalid ? m_if_word : 32'h0;
    exp_dbg_rvalid = reset && m_dbg_pend;
    exp_dbg_rdata  = exp_dbg_rvalid ? m_dbg_word : 32'h0;
    exp_busy       = reset && (m_if_pend || m_dbg_pend);
  endtask

  task automatic model_commit();
    if (!reset) begin
      model_reset();
      return;
    end
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    if (exp_if_gnt) m_perf_if = m_perf_if + 1;
    if (exp_dbg_gnt) m_perf_dbg = m_perf_dbg + 1;
    if (m_if_held && !if_ready) m_perf_stall = m_perf_stall + 1;
    m_if_held = !exp_if_gnt && m_if_pend && !if_ready && !flush;
`endif
    if (exp_if_gnt) begin
      m_if_pend = 1; m_if_word = mem_word(if_addr);
    end else if (!(m_if_pend && !if_ready && !flush)) begin
      m_if_pend = 0;
    end
    m_dbg_pend = exp_dbg_gnt;
    m_dbg_word = mem_word(dbg_addr);
    if (dbg_req && !exp_dbg_gnt) m_starve = (m_starve < MAXW) ? m_starve + 1 : m_starve;
    else m_starve = 0;
  endtask

  // Called at posedge+1: apply inputs, leave time to settle before the caller samples.
  task automatic drive(input logic ir, input logic [31:0] ia, input logic rdy, input logic dr,
                       input logic [31:0] da, input logic fl);
    if_req = ir; if_addr = ia; if_ready = rdy; dbg_req = dr; dbg_addr = da; flush = fl;
    model_eval();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 0;
    model_reset();
    @(posedge clk); #1;
    drive(1, 32'h10, 1, 1, 32'h20, 0);
    n_checks++;
    if ({if_gnt, dbg_gnt, ic_enable, busy, if_rvalid, dbg_rvalid} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {if_gnt, dbg_gnt, ic_enable, busy, if_rvalid, dbg_rvalid});
    end
    n_checks++;
    if (ic_addr !== 32'h0) begin
      n_errors++; $display("FAIL reset_ic_addr got=%h exp=0", ic_addr);
    end
    tick();
    reset = 1;
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({busy, if_rvalid, dbg_rvalid} !== 3'b0) begin
      n_errors++; $display("FAIL reset_release got=%b exp=000", {busy, if_rvalid, dbg_rvalid});
    end
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    n_checks++;
    if ({perf_if_fetches, perf_dbg_reads, perf_stall_cycles} !== 96'h0) begin
      n_errors++; $display("FAIL reset_perf got=%h/%h/%h exp=0", perf_if_fetches,
                           perf_dbg_reads, perf_stall_cycles);
    end
`endif
    tick();
  endtask

  task automatic test_stream();
    idle(2);
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1, 32'(c * 4), 1, 0, 0, 0);
      else drive(0, 0, 1, 0, 0, 0);
      n_checks++;
      if (if_gnt !== (c < 3)) begin
        n_errors++; $display("FAIL stream_gnt c=%0d got=%b exp=%b", c, if_gnt, c < 3);
      end
      n_checks++;
      if (ic_addr !== ((c < 3) ? 32'(c * 4) : 32'h0)) begin
        n_errors++; $display("FAIL stream_ic_addr c=%0d got=%h", c, ic_addr);
      end
      n_checks++;
      if (if_rdata !== ((c >= 1 && c <= 3) ? mem_word(32'((c - 1) * 4)) : 32'h0)) begin
        n_errors++; $display("FAIL stream_rdata c=%0d got=%h", c, if_rdata);
      end
      n_checks++;
      if ({if_rvalid, busy} !== {2{c >= 1 && c <= 3}}) begin
        n_errors++; $display("FAIL stream_valid_busy c=%0d got=%b", c, {if_rvalid, busy});
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    idle(2);
    for (int c = 1; c <= 12; c++) begin
      drive(1, 32'(32'h100 + 4 * c), 1, 1, 32'h800, 0);
      n_checks++;
      if ({dbg_gnt, if_gnt} !== {c == 9, c != 9}) begin
        n_errors++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, {dbg_gnt, if_gnt},
                             {c == 9, c != 9});
      end
      n_checks++;
      if ({dbg_rvalid, if_rvalid} !== {c == 10, c >= 2 && c != 10}) begin
        n_errors++; $display("FAIL starve_rvalid c=%0d got=%b", c, {dbg_rvalid, if_rvalid});
      end
      n_checks++;
      if (dbg_rdata !== ((c == 10) ? mem_word(32'h800) : 32'h0)) begin
        n_errors++; $display("FAIL starve_dbg_rdata c=%0d got=%h", c, dbg_rdata);
      end
      tick();
    end
    idle(2);
  endtask

  task automatic test_hold();
    idle(1);
    drive(1, 32'h10, 1, 0, 0, 0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      drive(1, 32'h20, 0, 1, 32'h30, 0);
      n_checks++;
      if ({if_rvalid, if_rdata} !== {1'b1, mem_word(32'h10)}) begin
        n_errors++; $display("FAIL hold_data c=%0d got=%b/%h", c, if_rvalid, if_rdata);
      end
      n_checks++;
      if ({if_gnt, dbg_gnt, ic_enable} !== 3'b0) begin
        n_errors++; $display("FAIL hold_no_gnt c=%0d got=%b", c, {if_gnt, dbg_gnt, ic_enable});
      end
      tick();
    end
    drive(1, 32'h20, 1, 0, 0, 0);
    n_checks++;
    if ({if_gnt, ic_addr, if_rdata} !== {1'b1, 32'h20, mem_word(32'h10)}) begin
      n_errors++; $display("FAIL hold_release got=%b/%h/%h", if_gnt, ic_addr, if_rdata);
    end
    tick();
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, mem_word(32'h20)}) begin
      n_errors++; $display("FAIL hold_next got=%b/%h", if_rvalid, if_rdata);
    end
    tick();
    idle(1);
  endtask

  task automatic test_flush();
    // flush during a fresh fetch response
    drive(1, 32'h40, 1, 0, 0, 0); tick();
    drive(1, 32'h44, 1, 0, 0, 1);
    n_checks++;
    if ({if_rvalid, if_gnt, if_rdata} !== 34'h0) begin
      n_errors++; $display("FAIL flush_resp got=%b/%b/%h", if_rvalid, if_gnt, if_rdata);
    end
    tick();
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({busy, if_rvalid} !== 2'b0) begin
      n_errors++; $display("FAIL flush_resp_idle got=%b", {busy, if_rvalid});
    end
    tick();
    // flush while a response is held
    drive(1, 32'h48, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (if_rvalid !== 1'b0) begin
      n_errors++; $display("FAIL flush_hold got=%b exp=0", if_rvalid);
    end
    tick();
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({busy, if_rvalid} !== 2'b0) begin
      n_errors++; $display("FAIL flush_hold_idle got=%b", {busy, if_rvalid});
    end
    tick();
    // flush leaves the debug response and debug arbitration alone
    drive(0, 0, 1, 1, 32'h84, 0);
    n_checks++;
    if (dbg_gnt !== 1'b1) begin
      n_errors++; $display("FAIL flush_dbg_gnt got=%b exp=1", dbg_gnt);
    end
    tick();
    drive(1, 32'h50, 1, 0, 0, 1);
    n_checks++;
    if ({dbg_rvalid, dbg_rdata, if_gnt} !== {1'b1, mem_word(32'h84), 1'b0}) begin
      n_errors++; $display("FAIL flush_dbg_resp got=%b/%h/%b", dbg_rvalid, dbg_rdata, if_gnt);
    end
    tick();
    drive(1, 32'h58, 1, 0, 0, 0); tick();
    drive(1, 32'h5C, 1, 1, 32'h88, 1);
    n_checks++;
    if ({dbg_gnt, if_gnt, if_rvalid} !== 3'b0) begin
      n_errors++; $display("FAIL flush_dbg_prio got=%b exp=000", {dbg_gnt, if_gnt, if_rvalid});
    end
    tick();
    idle(2);
  endtask

  task automatic test_reset_hold();
    drive(1, 32'h10, 1, 0, 0, 0); tick();
    drive(1, 32'h14, 0, 1, 32'h90, 0); tick();
    drive(1, 32'h14, 0, 1, 32'h90, 0);
    n_checks++;
    if (if_rvalid !== 1'b1) begin
      n_errors++; $display("FAIL rsthold_pre got=%b exp=1", if_rvalid);
    end
    #1 reset = 0;
    model_reset();
    #1;
    n_checks++;
    if ({if_gnt, dbg_gnt, ic_enable, if_rvalid, dbg_rvalid, busy} !== 6'b0) begin
      n_errors++; $display("FAIL rsthold_ctrl got=%b exp=000000",
                           {if_gnt, dbg_gnt, ic_enable, if_rvalid, dbg_rvalid, busy});
    end
    n_checks++;
    if ({if_rdata, dbg_rdata, ic_addr} !== 96'h0) begin
      n_errors++; $display("FAIL rsthold_data got=%h/%h/%h", if_rdata, dbg_rdata, ic_addr);
    end
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    n_checks++;
    if ({perf_if_fetches, perf_dbg_reads, perf_stall_cycles} !== 96'h0) begin
      n_errors++; $display("FAIL rsthold_perf got=%h/%h/%h exp=0", perf_if_fetches,
                           perf_dbg_reads, perf_stall_cycles);
    end
`endif
    tick();
    reset = 1;
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({if_rvalid, dbg_rvalid, busy} !== 3'b0) begin
      n_errors++; $display("FAIL rsthold_release got=%b exp=000", {if_rvalid, dbg_rvalid, busy});
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 32'($urandom_range(0, 4095)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, 32'($urandom_range(0, 4095)), $urandom_range(0, 9) == 0);
      n_checks++;
      if ({if_gnt, dbg_gnt, ic_enable, if_rvalid, dbg_rvalid, busy} !==
          {exp_if_gnt, exp_dbg_gnt, exp_ic_enable, exp_if_rvalid, exp_dbg_rvalid, exp_busy}) begin
        n_errors++;
        $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i,
                 {if_gnt, dbg_gnt, ic_enable, if_rvalid, dbg_rvalid, busy},
                 {exp_if_gnt, exp_dbg_gnt, exp_ic_enable, exp_if_rvalid, exp_dbg_rvalid, exp_busy});
      end
      n_checks++;
      if ({ic_addr, if_rdata, dbg_rdata} !== {exp_ic_addr, exp_if_rdata, exp_dbg_rdata}) begin
        n_errors++;
        $display("FAIL rand_data i=%0d got=%h/%h/%h exp=%h/%h/%h", i, ic_addr, if_rdata,
                 dbg_rdata, exp_ic_addr, exp_if_rdata, exp_dbg_rdata);
      end
      tick();
    end
`ifdef ICACHE_FETCH_CTRL_PERF_EN
    drive(0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({perf_if_fetches, perf_dbg_reads, perf_stall_cycles} !==
        {m_perf_if, m_perf_dbg, m_perf_stall}) begin
      n_errors++; $display("FAIL rand_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_if_fetches,
                           perf_dbg_reads, perf_stall_cycles, m_perf_if, m_perf_dbg, m_perf_stall);
    end
    tick();
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_starvation();
    test_hold();
    test_flush();
    test_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
